execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/muldiv_iter.sv | 49 ++++
 rtl/execute_muldiv.sv | 204 ++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32 M-extension execute unit:
//   XLEN            - datapath width
//   mdOpE           - funct3 encodings of the eight M-extension operations
//   mdStateE        - state encoding of the multiply/divide sequencer
//   DIV_BY_ZERO_Q   - quotient returned for a zero divisor
//   INT_MIN         - most negative XLEN-bit integer (signed overflow case)
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdOpE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdStateE;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

    // Two's-complement negate when neg is set; used for magnitudes and for
    // restoring the sign of results.
    function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] v,
                                                input logic            neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// One combinational iteration of either an unsigned shift-add multiply or an
// unsigned restoring divide. The caller holds {hi, lo} and the operand in
// registers and feeds the outputs back once per cycle.
//   isDiv_i  in   1  1 = divide step, 0 = multiply step
//   hi_i     in  32  multiply: upper product half / divide: partial remainder
//   lo_i     in  32  multiply: multiplier shifting into lower product half
//                    divide:   dividend shifting out, quotient shifting in
//   opB_i    in  32  multiplicand or divisor magnitude
//   hi_o     out 32  next hi
//   lo_o     out 32  next lo
// ---------------------------------------------------------------------------
module muldiv_iter (
    input  logic        isDiv_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] opB_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [32:0] mulSum;
    logic [32:0] shifted;
    logic        geDivisor;
    logic [31:0] trialRem;

    // Multiply: conditionally add the multiplicand into the top half, then
    // shift the 65-bit {carry, hi, lo} right so the next multiplier bit lands
    // in lo[0]. Divide: shift the remainder left pulling in the next dividend
    // bit; shifted can reach 33 bits, but whenever it is >= divisor the
    // difference is below the divisor, so 32-bit wrap-around arithmetic is
    // exact for the restored remainder.
    always_comb begin
        mulSum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opB_i} : 33'd0);
        shifted   = {hi_i, lo_i[31]};
        geDivisor = (shifted >= {1'b0, opB_i});
        trialRem  = shifted[31:0] - opB_i;

        if (isDiv_i) begin
            hi_o = geDivisor ? trialRem : shifted[31:0];
            lo_o = {lo_i[30:0], geDivisor};
        end else begin
            hi_o = mulSum[32:1];
            lo_o = {mulSum[0], lo_i[31:1]};
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// ---------------------------------------------------------------------------
// execute_muldiv
// Multi-cycle RV32M multiply/divide unit in the execute stage. Operands are
// captured as magnitudes, iterated 32 times through muldiv_iter, then the
// sign is restored and the requested half/quotient/remainder selected.
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   startE   in   1  M-op present in execute (held while stalled)
//   flushE   in   1  synchronous kill of the in-flight operation
//   funct3E  in   3  operation select (mdOpE)
//   SrcAE    in  32  rs1 operand
//   SrcBE    in  32  rs2 operand
//   StallMD  out  1  freezes fetch/decode/execute while a result is pending
//   DoneMD   out  1  single-cycle pulse, ResultMD valid
//   ResultMD out 32  result, held until the next completed operation
// ---------------------------------------------------------------------------
module execute_muldiv
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        startE,
    input  logic        flushE,
    input  logic [2:0]  funct3E,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    output logic        StallMD,
    output logic        DoneMD,
    output logic [31:0] ResultMD
);

    mdStateE     state_q,  state_d;
    logic [4:0]  count_q,  count_d;
    logic        served_q, served_d;
    mdOpE        op_q,     op_d;
    logic        neg_q,    neg_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    logic [31:0] opB_q,    opB_d;
    logic [31:0] result_q, result_d;

    logic        accept;
    logic        signA, signB;
    logic        negIn;
    logic        divZero, divOverflow;
    logic [31:0] magA, magB;
    logic [31:0] iterHi, iterLo;
    logic [63:0] prodSigned;
    logic [31:0] finalResult;

    muldiv_iter u_iter (
        .isDiv_i (op_q[2]),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .opB_i   (opB_q),
        .hi_o    (iterHi),
        .lo_o    (iterLo)
    );

    // Operand decode at start time. Only operands that the op treats as
    // signed contribute a sign; MULHSU keeps rs2 unsigned. MUL needs no sign
    // handling because the low product half is sign-agnostic.
    always_comb begin
        signA = SrcAE[31] && (funct3E == F3_MULH || funct3E == F3_MULHSU ||
                              funct3E == F3_DIV  || funct3E == F3_REM);
        signB = SrcBE[31] && (funct3E == F3_MULH || funct3E == F3_DIV ||
                              funct3E == F3_REM);
        magA  = condNeg(SrcAE, signA);
        magB  = condNeg(SrcBE, signB);

        case (funct3E)
            F3_MULH:   negIn = signA ^ signB;
            F3_MULHSU: negIn = signA;
            F3_DIV:    negIn = signA ^ signB;
            F3_REM:    negIn = signA;
            default:   negIn = 1'b0;
        endcase

        divZero     = funct3E[2] && (SrcBE == 32'd0);
        divOverflow = (funct3E == F3_DIV || funct3E == F3_REM) &&
                      (SrcAE == INT_MIN) && (SrcBE == DIV_BY_ZERO_Q);
    end

    // A start is refused while the same instruction is still being held
    // after its result was delivered (served_q).
    assign accept = (state_q == IDLE) && startE && !flushE && !served_q;

    // neg_q means "negate the product" for multiplies, "negate the quotient"
    // for DIV and "negate the remainder" for REM; the two halves of {hi,lo}
    // are product halves or remainder/quotient depending on the op.
    always_comb begin
        prodSigned = {hi_q, lo_q};
        if (neg_q) begin
            prodSigned = ~{hi_q, lo_q} + 64'd1;
        end

        case (op_q)
            F3_MUL:                        finalResult = prodSigned[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  finalResult = prodSigned[63:32];
            F3_DIV, F3_DIVU:               finalResult = condNeg(lo_q, neg_q);
            F3_REM, F3_REMU:               finalResult = condNeg(hi_q, neg_q);
            default:                       finalResult = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opB_d    = opB_q;
        result_d = result_q;

        if (flushE || !startE) begin
            served_d = 1'b0;
        end else if (state_q == DONE) begin
            served_d = 1'b1;
        end else begin
            served_d = served_q;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = mdOpE'(funct3E);
                    count_d = 5'd0;
                    opB_d   = magB;
                    // The two special divide cases preload the final
                    // quotient (lo) and remainder (hi) and bypass iteration.
                    if (divZero) begin
                        hi_d    = SrcAE;
                        lo_d    = DIV_BY_ZERO_Q;
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end else if (divOverflow) begin
                        hi_d    = 32'd0;
                        lo_d    = INT_MIN;
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        hi_d    = 32'd0;
                        lo_d    = magA;
                        neg_d   = negIn;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                hi_d = iterHi;
                lo_d = iterLo;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end
            DONE: begin
                result_d = finalResult;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush wins over everything, including the result update in DONE.
        if (flushE) begin
            state_d  = IDLE;
            count_d  = 5'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            served_q <= 1'b0;
            op_q     <= F3_MUL;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            opB_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            served_q <= served_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opB_q    <= opB_d;
            result_q <= result_d;
        end
    end

    // The stall covers the start cycle itself (combinational on startE) and
    // is forced low while reset is held, even if startE stays high.
    assign StallMD  = rst_n && (accept || (state_q == CALC));
    assign DoneMD   = (state_q == DONE) && !flushE;
    assign ResultMD = DoneMD ? finalResult : result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
module tb_execute_muldiv;

    logic        clk;
    logic        rst_n;
    logic        startE;
    logic        flushE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        StallMD;
    logic        DoneMD;
    logic [31:0] ResultMD;

    int checks = 0;
    int errors = 0;

    execute_muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .startE   (startE),
        .flushE   (flushE),
        .funct3E  (funct3E),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .StallMD  (StallMD),
        .DoneMD   (DoneMD),
        .ResultMD (ResultMD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of an M-extension op, straight from the ISA rules.
    function automatic logic [31:0] refResult(input logic [2:0]  f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'(ua); return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Zero divisor and signed overflow complete without iterating.
    function automatic bit isShortOp(input logic [2:0]  f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (!f3[0]) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Reference model: cycles remaining until the result cycle (0 = idle),
    // the pending and the held result, and whether the held instruction has
    // already been served.
    int          mRemain;
    logic [31:0] mPend;
    logic [31:0] mHeld;
    bit          mServed;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRemain <= 0;
            mPend   <= 32'd0;
            mHeld   <= 32'd0;
            mServed <= 1'b0;
        end else begin
            if (flushE) begin
                mRemain <= 0;
            end else if (mRemain == 0) begin
                if (startE && !mServed) begin
                    mRemain <= isShortOp(funct3E, SrcAE, SrcBE) ? 1 : 33;
                    mPend   <= refResult(funct3E, SrcAE, SrcBE);
                end
            end else if (mRemain == 1) begin
                mHeld   <= mPend;
                mRemain <= 0;
            end else begin
                mRemain <= mRemain - 1;
            end

            if (flushE || !startE) begin
                mServed <= 1'b0;
            end else if (mRemain == 1) begin
                mServed <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    logic        eStall;
    logic        eDone;
    logic [31:0] eRes;

    always @(negedge clk) begin
        if (mRemain == 0) begin
            eStall = rst_n && startE && !flushE && !mServed;
            eDone  = 1'b0;
            eRes   = mHeld;
        end else if (mRemain == 1) begin
            eStall = 1'b0;
            eDone  = !flushE;
            eRes   = flushE ? mHeld : mPend;
        end else begin
            eStall = 1'b1;
            eDone  = 1'b0;
            eRes   = mHeld;
        end
        checkOutput("StallMD",  {31'd0, StallMD}, {31'd0, eStall});
        checkOutput("DoneMD",   {31'd0, DoneMD},  {31'd0, eDone});
        checkOutput("ResultMD", ResultMD, eRes);
    end

    // Issue one op with startE held, scramble operands once accepted, and pin
    // the result and latency. Latency counts the start cycle as cycle 1: a
    // normal op shows DoneMD in cycle 34, a short op in cycle 2 (the cycle
    // right after the accepting edge). startE is kept high one extra cycle
    // after DoneMD to make sure the same instruction is not restarted.
    task automatic applyStimulus(input logic [2:0]  f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [31:0] expRes,
                                 input int          expCycles,
                                 input string       name);
        int n;
        bit seen;
        startE  = 1'b1;
        funct3E = f3;
        SrcAE   = a;
        SrcBE   = b;
        n       = 1;
        seen    = 1'b0;
        while (!seen && n <= 60) begin
            @(negedge clk);
            if (DoneMD) begin
                seen = 1'b1;
                checkOutput({name, " result"}, ResultMD, expRes);
                checkOutput({name, " latency"}, 32'(n), 32'(expCycles));
            end
            @(posedge clk);
            #1;
            SrcAE = $urandom;
            SrcBE = $urandom;
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: no DoneMD within %0d cycles, required 1 pulse", name, n);
        end
        @(posedge clk);
        #1;
        startE = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prevResult;

    initial begin
        rst_n   = 1'b0;
        startE  = 1'b0;
        flushE  = 1'b0;
        funct3E = 3'b000;
        SrcAE   = 32'd0;
        SrcBE   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ResultMD", ResultMD, 32'd0);
        checkOutput("reset StallMD", {31'd0, StallMD}, 32'd0);
        checkOutput("reset DoneMD", {31'd0, DoneMD}, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7*-3");
        applyStimulus(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, "MULH min*min");
        applyStimulus(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU max*max");
        applyStimulus(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, "MULHSU -1*2");
        applyStimulus(3'b001, 32'd3,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, "MULH 3*-5");
        applyStimulus(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "DIV -7/2");
        applyStimulus(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "REM -7/2");
        applyStimulus(3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         34, "REM 7/-2");
        applyStimulus(3'b101, 32'd100,        32'd7,         32'd14,        34, "DIVU 100/7");
        applyStimulus(3'b111, 32'd100,        32'd7,         32'd2,         34, "REMU 100/7");
        applyStimulus(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  "DIV 5/0");
        applyStimulus(3'b111, 32'd5,          32'd0,         32'd5,         2,  "REMU 5/0");
        applyStimulus(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  "DIV min/-1");
        applyStimulus(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,  "REM min/-1");

        // Flush while the counter reads 10: no DoneMD, result retained.
        prevResult = 32'd0;
        startE  = 1'b1;
        funct3E = 3'b000;
        SrcAE   = 32'd12345;
        SrcBE   = 32'd678;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        flushE = 1'b1;
        @(posedge clk);
        #1;
        flushE = 1'b0;
        startE = 1'b0;
        checkOutput("flush keeps ResultMD", ResultMD, prevResult);
        checkOutput("flush no DoneMD", {31'd0, DoneMD}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(3'b101, 32'd9, 32'd3, 32'd3, 34, "DIVU 9/3 after flush");

        // Reset pulse at counter 20 with startE held high throughout.
        startE  = 1'b1;
        funct3E = 3'b011;
        SrcAE   = 32'hFFFF_FFFF;
        SrcBE   = 32'hFFFF_FFFF;
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid-op reset ResultMD", ResultMD, 32'd0);
        checkOutput("mid-op reset StallMD", {31'd0, StallMD}, 32'd0);
        checkOutput("mid-op reset DoneMD", {31'd0, DoneMD}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
